reg_serializer: RTL and testbench

Parallel-in, serial-out companion to the team's N-bit parallel register. It accepts an N-bit word over a valid/ready load handshake and drives it out one bit per accepted beat on a serial valid/ready interface. It sits between a register's parallel output and any bit-serial consumer, such as a link or a debug scan path.

---
 rtl/reg_serializer.sv | 96 +++++++++
 tb/tb_reg_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_serializer.sv
// Parallel-in, serial-out shifter: captures an N-bit word on a valid/ready load
// handshake and emits it one bit per accepted beat on a serial valid/ready port.
module reg_serializer #(
  parameter int N         = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] I,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [N-1:0]   shreg_r, shreg_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           shifting_s;
  logic           last_s;
  logic           head_s;

  assign shifting_s = (state_r == SHIFT);
  assign last_s     = shifting_s && (cnt_r == CNT_LAST);
  assign head_s     = LSB_FIRST ? shreg_r[0] : shreg_r[N-1];

  // Next-state logic: load in IDLE, shift or finish on a beat in SHIFT.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          state_s = SHIFT;
          shreg_s = I;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          if (last_s) begin
            state_s = IDLE;
            shreg_s = {N{1'b0}};
            cnt_s   = {CW{1'b0}};
          end else begin
            // Zero-fill from the end opposite the output bit.
            shreg_s = LSB_FIRST ? {1'b0, shreg_r[N-1:1]} : {shreg_r[N-2:0], 1'b0};
            cnt_s   = cnt_r + CW'(1);
          end
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        shreg_s = {N{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      shreg_r <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
    end
  end

  // Reset gates load_ready directly so no word is offered while reset is held.
  assign load_ready = (state_r == IDLE) && !reset;
  assign sout_valid = shifting_s;
  assign busy       = shifting_s;
  assign last       = last_s;
  assign sout       = shifting_s && head_s;

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: a 32-bit LSB-first and an 8-bit
// MSB-first instance checked every cycle against queue-based reference models.
module tb_reg_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        sout_ready = 1'b0;
  logic [31:0] i32 = 32'h0;
  logic [7:0]  i8 = 8'h0;

  logic load_ready32, sout32, sout_valid32, last32, busy32;
  logic load_ready8, sout8, sout_valid8, last8, busy8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference models: the bits still to be sent, in send order.
  bit q32[$];
  bit q8[$];
  // Observed beats (bit, last flag, edge number) and load-accept edges.
  bit b32[$];
  bit l32[$];
  int e32[$];
  int a32[$];
  bit b8[$];
  bit l8[$];
  int e8[$];
  int a8[$];

  int base32, base8, ab32, ab8, n0;

  always #5 clk = ~clk;

  reg_serializer #(.N(32), .LSB_FIRST(1'b1)) dut32 (
    .clk(clk), .reset(reset), .I(i32), .load_valid(load_valid),
    .load_ready(load_ready32), .sout(sout32), .sout_valid(sout_valid32),
    .sout_ready(sout_ready), .last(last32), .busy(busy32)
  );

  reg_serializer #(.N(8), .LSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .I(i8), .load_valid(load_valid),
    .load_ready(load_ready8), .sout(sout8), .sout_valid(sout_valid8),
    .sout_ready(sout_ready), .last(last8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(load_ready32 && load_ready8) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 300), 32'd1);
  endtask

  function automatic logic [31:0] pack32(input int base);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 32; i++) if (base + i < b32.size()) v[i] = b32[base + i];
    return v;
  endfunction

  function automatic logic [31:0] lmask32(input int base);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 32; i++) if (base + i < l32.size()) v[i] = l32[base + i];
    return v;
  endfunction

  function automatic logic [7:0] pack8(input int base);
    logic [7:0] v;
    v = 8'h0;
    for (int i = 0; i < 8; i++) if (base + i < b8.size()) v[7 - i] = b8[base + i];
    return v;
  endfunction

  function automatic logic [7:0] lmask8(input int base);
    logic [7:0] v;
    v = 8'h0;
    for (int i = 0; i < 8; i++) if (base + i < l8.size()) v[7 - i] = l8[base + i];
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model update: one bit leaves on each accepted beat; a load queues the word.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q32.delete();
      q8.delete();
    end else begin
      if (q32.size() != 0) begin
        if (sout_ready) q32.delete(0);
      end else if (load_valid) begin
        for (int i = 0; i < 32; i++) q32.push_back(i32[i]);
      end
      if (q8.size() != 0) begin
        if (sout_ready) q8.delete(0);
      end else if (load_valid) begin
        for (int i = 7; i >= 0; i--) q8.push_back(i8[i]);
      end
    end
  end

  // Per-cycle comparison of both instances against the models.
  always @(negedge clk) begin
    chk("ready32", 32'(load_ready32), 32'((q32.size() == 0) && !reset));
    chk("valid32", 32'(sout_valid32), 32'(q32.size() != 0));
    chk("busy32",  32'(busy32),       32'(q32.size() != 0));
    chk("last32",  32'(last32),       32'(q32.size() == 1));
    chk("sout32",  32'(sout32),       32'((q32.size() != 0) ? q32[0] : 1'b0));
    chk("ready8",  32'(load_ready8),  32'((q8.size() == 0) && !reset));
    chk("valid8",  32'(sout_valid8),  32'(q8.size() != 0));
    chk("busy8",   32'(busy8),        32'(q8.size() != 0));
    chk("last8",   32'(last8),        32'(q8.size() == 1));
    chk("sout8",   32'(sout8),        32'((q8.size() != 0) ? q8[0] : 1'b0));
  end

  // Beat and load-accept recorder; stamps the edge on which each will happen.
  always @(negedge clk) begin
    if (sout_valid32 && sout_ready) begin
      b32.push_back(sout32); l32.push_back(last32); e32.push_back(cyc + 1);
    end
    if (sout_valid8 && sout_ready) begin
      b8.push_back(sout8); l8.push_back(last8); e8.push_back(cyc + 1);
    end
    if (load_ready32 && load_valid) a32.push_back(cyc + 1);
    if (load_ready8 && load_valid) a8.push_back(cyc + 1);
  end

  initial begin
    tick();
    chk("rst_ready", 32'(load_ready32), 32'd0);
    chk("rst_valid", 32'(sout_valid32), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(load_ready32), 32'd1);
    chk("post_rst_valid", 32'(sout_valid32), 32'd0);
    chk("post_rst_sout",  32'(sout32),       32'd0);
    chk("post_rst_last",  32'(last32),       32'd0);
    chk("post_rst_busy",  32'(busy32),       32'd0);

    // Word A5A5_0F0F on the LSB-first instance, 8'h81 on the MSB-first one.
    wait_idle();
    sout_ready = 1'b1;
    base32 = b32.size(); base8 = b8.size(); ab32 = a32.size(); ab8 = a8.size();
    i32 = 32'hA5A5_0F0F; i8 = 8'h81; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("model_len32", 32'(q32.size()), 32'd32);
    chk("model_first32", 32'(q32[0]), 32'd1);
    chk("model_first8", 32'(q8[0]), 32'd1);
    repeat (31) tick();
    chk("t1_last", 32'(last32), 32'd1);
    tick();
    chk("t1_ready_back", 32'(load_ready32), 32'd1);
    chk("t1_beats", 32'(b32.size() - base32), 32'd32);
    chk("t1_word", pack32(base32), 32'hA5A5_0F0F);
    chk("t1_lastmask", lmask32(base32), 32'h8000_0000);
    chk("t1_duration", 32'(e32[e32.size() - 1] - a32[ab32]), 32'd32);
    chk("t2_beats", 32'(b8.size() - base8), 32'd8);
    chk("t2_word", 32'(pack8(base8)), 32'h81);
    chk("t2_lastmask", 32'(lmask8(base8)), 32'h01);
    chk("t2_duration", 32'(e8[e8.size() - 1] - a8[ab8]), 32'd8);

    // Five-cycle stall after beat 3 of 32'h1.
    wait_idle();
    base32 = b32.size(); ab32 = a32.size();
    i32 = 32'h0000_0001; i8 = 8'($urandom); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    sout_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_sout", 32'(sout32), 32'd0);
      chk("stall_last", 32'(last32), 32'd0);
      chk("stall_valid", 32'(sout_valid32), 32'd1);
    end
    sout_ready = 1'b1;
    wait_idle();
    chk("t3_beats", 32'(b32.size() - base32), 32'd32);
    chk("t3_word", pack32(base32), 32'h0000_0001);
    chk("t3_duration", 32'(e32[e32.size() - 1] - a32[ab32]), 32'd37);

    // Load attempts during SHIFT must be ignored.
    wait_idle();
    base32 = b32.size();
    i32 = 32'h1234_5678; load_valid = 1'b1;
    tick();
    i32 = 32'hFFFF_FFFF;
    repeat (20) begin
      chk("shift_no_ready", 32'(load_ready32), 32'd0);
      tick();
    end
    load_valid = 1'b0;
    wait_idle();
    chk("t4_beats", 32'(b32.size() - base32), 32'd32);
    chk("t4_word", pack32(base32), 32'h1234_5678);

    // Asynchronous reset in the middle of a word.
    wait_idle();
    i32 = 32'hDEAD_BEEF; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (10) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(sout_valid32), 32'd0);
    chk("arst_busy", 32'(busy32), 32'd0);
    chk("arst_last", 32'(last32), 32'd0);
    chk("arst_sout", 32'(sout32), 32'd0);
    chk("arst_ready", 32'(load_ready32), 32'd0);
    n0 = a32.size();
    load_valid = 1'b1; i32 = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("arst_no_load", 32'(a32.size() - n0), 32'd0);
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(load_ready32), 32'd1);
    chk("rel_valid", 32'(sout_valid32), 32'd0);
    wait_idle();
    base32 = b32.size();
    i32 = 32'h8000_0000; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    wait_idle();
    chk("t5_beats", 32'(b32.size() - base32), 32'd32);
    chk("t5_word", pack32(base32), 32'h8000_0000);

    // Back-to-back loads with load_valid held high.
    wait_idle();
    base32 = b32.size(); ab32 = a32.size();
    i32 = 32'h1; load_valid = 1'b1;
    tick();
    i32 = 32'h2;
    repeat (33) tick();
    load_valid = 1'b0;
    wait_idle();
    chk("t6_accepts", 32'(a32.size() - ab32), 32'd2);
    chk("t6_spacing", 32'(a32[ab32 + 1] - a32[ab32]), 32'd33);
    chk("t6_beats", 32'(b32.size() - base32), 32'd64);
    chk("t6_word1", pack32(base32), 32'h1);
    chk("t6_word2", pack32(base32 + 32), 32'h2);

    // Randomized traffic with occasional asynchronous resets.
    repeat (4000) begin
      load_valid = ($urandom_range(0, 3) == 0);
      sout_ready = ($urandom_range(0, 3) != 0);
      i32 = $urandom;
      i8 = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; load_valid = 1'b0; sout_ready = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
